// File: rtl/fx3_burst_writer.sv
// FX3 GPIF burst writer: pops 10-bit offset-binary samples from a show-ahead FIFO and writes them as
// 16-bit signed words in flag-paced bursts. Optional FX3_WORD_COUNT_EN builds the 32-bit written-word counter.
module fx3_burst_writer #(
  parameter int unsigned MAX_BURST = 8192,
  parameter int unsigned CNT_W     = 14
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  fifoData,
  input  logic        fifoDataReady,
  output logic        fifoAck,
  input  logic        fx3Ready,
  input  logic        fx3Watermark,
  output logic [15:0] fx3Data,
  output logic        fx3nWrite,
  output logic        burstActive,
  output logic        errorFlag,
  output logic [31:0] wordCount
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BURST  = 2'd1,
    S_DRAIN  = 2'd2,
    S_SWITCH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  state_t           r_state;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [15:0]      r_data;
  logic             r_nwrite;
  logic             r_burst_active;
  logic             r_error;

  logic w_cnt_room;
  logic w_ack;

  // Pop is combinational so the show-ahead head word is consumed in the same cycle it is seen.
  assign w_cnt_room = (r_burst_cnt < CNT_MAX);
  assign w_ack      = (r_state == S_BURST) & fifoDataReady & ~fx3Watermark & w_cnt_room;

  assign fifoAck     = w_ack;
  assign fx3Data     = r_data;
  assign fx3nWrite   = r_nwrite;
  assign burstActive = r_burst_active;
  assign errorFlag   = r_error;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_burst_cnt    <= '0;
      r_data         <= 16'h0000;
      r_nwrite       <= 1'b1;
      r_burst_active <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_nwrite <= ~w_ack;
      // Flipping the MSB turns offset-binary into two's complement; left-justify into 16 bits.
      if (w_ack) begin
        r_data <= {fifoData ^ 10'h200, 6'b000000};
      end

      case (r_state)
        S_IDLE: begin
          if (fx3Ready & ~fx3Watermark) begin
            r_state        <= S_BURST;
            r_burst_cnt    <= '0;
            r_burst_active <= 1'b1;
          end
        end
        S_BURST: begin
          if (w_ack) begin
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
          end
          // FX3 withdrawing ready without a watermark warning is a protocol violation.
          if (~fx3Ready & ~fx3Watermark) begin
            r_error <= 1'b1;
          end
          if (fx3Watermark | ~w_cnt_room | ~fx3Ready) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_state        <= S_SWITCH;
          r_burst_active <= 1'b0;
        end
        S_SWITCH: begin
          if (~fx3Ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_burst_active <= 1'b0;
        end
      endcase
    end
  end

`ifdef FX3_WORD_COUNT_EN
  logic [31:0] r_word_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_word_count <= 32'h0;
    end else if (~r_nwrite) begin
      r_word_count <= r_word_count + 32'd1;
    end
  end

  assign wordCount = r_word_count;
`else
  assign wordCount = 32'h0;
`endif

endmodule

// File: tb/tb_fx3_burst_writer.sv
// Scoreboard bench for fx3_burst_writer: a FIFO model feeds random samples, a legal FX3 host paces bursts,
// and a negedge monitor checks every strobed word, ack legality, burst length and wordCount.
module tb_fx3_burst_writer;

  localparam int unsigned MAXB = 4;

  logic        clock;
  logic        reset;
  logic [9:0]  fifoData;
  logic        fifoDataReady;
  logic        fifoAck;
  logic        fx3Ready;
  logic        fx3Watermark;
  logic [15:0] fx3Data;
  logic        fx3nWrite;
  logic        burstActive;
  logic        errorFlag;
  logic [31:0] wordCount;

  fx3_burst_writer #(.MAX_BURST(MAXB), .CNT_W(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .fifoData     (fifoData),
    .fifoDataReady(fifoDataReady),
    .fifoAck      (fifoAck),
    .fx3Ready     (fx3Ready),
    .fx3Watermark (fx3Watermark),
    .fx3Data      (fx3Data),
    .fx3nWrite    (fx3nWrite),
    .burstActive  (burstActive),
    .errorFlag    (errorFlag),
    .wordCount    (wordCount)
  );

  logic [9:0]  fifo_q[$];
  logic [15:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] n_writes = 32'h0;
  int          burst_acks = 0;
  logic        prev_active = 1'b0;
  logic        stall_en = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference conversion: centre on mid-scale and scale to the 16-bit range.
  function automatic logic [15:0] conv(input logic [9:0] x);
    int v;
    v = (int'(x) - 512) * 64;
    return 16'(v);
  endfunction

  task automatic push(input logic [9:0] x);
    fifo_q.push_back(x);
    exp_q.push_back(conv(x));
  endtask

  task automatic drive_fifo();
    if (fifo_q.size() > 0 && !(stall_en && $urandom_range(2) == 0)) begin
      fifoDataReady = 1'b1;
      fifoData      = fifo_q[0];
    end else begin
      fifoDataReady = 1'b0;
      fifoData      = 10'($urandom);
    end
  endtask

  // One clock: sample at negedge, then update FIFO model and inputs just after the rising edge.
  task automatic cycle(output logic ack, output logic nw, output logic act);
    @(negedge clock);
    ack = fifoAck;
    nw  = fx3nWrite;
    act = burstActive;
    @(posedge clock);
    #2;
    if (ack && fifo_q.size() > 0) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  task automatic step(input int n);
    logic a, w, b;
    for (int i = 0; i < n; i++) cycle(a, w, b);
  endtask

  task automatic end_burst();
    fx3Watermark = 1'b1;
    step(2);
    fx3Ready = 1'b0;
    step(2);
    fx3Watermark = 1'b0;
    step(1 + $urandom_range(2));
  endtask

  task automatic rand_burst(input int n_new);
    logic a, w, b;
    bit   seen;
    int   len;
    for (int i = 0; i < n_new; i++) push(10'($urandom));
    drive_fifo();
    fx3Ready     = 1'b1;
    fx3Watermark = 1'b0;
    len  = 1 + $urandom_range(9);
    seen = 0;
    for (int i = 0; i < len; i++) begin
      cycle(a, w, b);
      if (burstActive) seen = 1;
      else if (seen) break;
    end
    end_burst();
    check("no_error", 32'(errorFlag), 32'h0);
  endtask

  // Monitor: scoreboard pop on every strobe, plus ack legality, burst length and word count.
  always @(negedge clock) begin
    logic [31:0] exp_wc;
    if (reset) begin
      n_writes    = 32'h0;
      burst_acks  = 0;
      prev_active = 1'b0;
    end else begin
`ifdef FX3_WORD_COUNT_EN
      exp_wc = n_writes;
`else
      exp_wc = 32'h0;
`endif
      check("word_count", wordCount, exp_wc);
      if (!fx3nWrite) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got data %h, expected no strobe (t=%0t)", fx3Data, $time);
        end else begin
          check("fx3_data", 32'(fx3Data), 32'(exp_q.pop_front()));
        end
        n_writes = n_writes + 32'd1;
      end
      if (fifoAck) begin
        check("ack_legal{rdy,wm,active}", 32'({fifoDataReady, fx3Watermark, burstActive}), 32'h5);
        burst_acks++;
      end
      if (prev_active && !burstActive) begin
        check("burst_len_le_max", 32'(burst_acks <= int'(MAXB)), 32'h1);
        burst_acks = 0;
      end
      prev_active = burstActive;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic a1, a2, a3, a4, w1, w2, w3, w4, b1, b2, b3, b4;
    int   acks;
    bit   seen, done;

    reset         = 1'b0;
    fifoData      = 10'h0;
    fifoDataReady = 1'b0;
    fx3Ready      = 1'b0;
    fx3Watermark  = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_fifoAck", 32'(fifoAck), 32'h0);
    check("rst_nWrite", 32'(fx3nWrite), 32'h1);
    check("rst_data", 32'(fx3Data), 32'h0);
    check("rst_active", 32'(burstActive), 32'h0);
    check("rst_error", 32'(errorFlag), 32'h0);
    check("rst_wordCount", wordCount, 32'h0);
    @(posedge clock);
    #2 reset = 1'b0;

    // Steady stream of the reference examples.
    push(10'd0); push(10'd512); push(10'd1023);
    drive_fifo();
    fx3Ready = 1'b1;
    step(8);
    check("steady_active", 32'(burstActive), 32'h1);
    check("steady_all_written", 32'(exp_q.size()), 32'h0);
    check("steady_data_hold", 32'(fx3Data), 32'h7FC0);
    check("steady_nwrite_idle", 32'(fx3nWrite), 32'h1);
    end_burst();

    // Bubble pattern: data ready 1,0,1.
    fx3Ready = 1'b1;
    step(1);
    push(10'd100);
    drive_fifo();
    cycle(a1, w1, b1);
    cycle(a2, w2, b2);
    push(10'd900);
    drive_fifo();
    cycle(a3, w3, b3);
    cycle(a4, w4, b4);
    check("bubble_acks", 32'({a1, a2, a3, a4}), 32'hA);
    check("bubble_strobes", 32'({w1, w2, w3, w4}), 32'hA);
    end_burst();

    // Watermark ends the burst after two acks.
    for (int i = 0; i < 6; i++) push(10'(1000 - i * 37));
    drive_fifo();
    fx3Ready = 1'b1;
    step(1);
    cycle(a1, w1, b1);
    cycle(a2, w2, b2);
    fx3Watermark = 1'b1;
    cycle(a3, w3, b3);
    cycle(a4, w4, b4);
    check("wm_acks_before", 32'({a1, a2}), 32'h3);
    check("wm_no_ack", 32'({a3, a4}), 32'h0);
    check("wm_active_burst_drain", 32'({b3, b4}), 32'h3);
    cycle(a1, w1, b1);
    check("wm_drain_one_cycle", 32'(b1), 32'h0);
    check("wm_two_strobes", 32'(exp_q.size()), 32'h4);
    fx3Watermark = 1'b0;
    step(3);
    check("switch_holds", 32'(burstActive), 32'h0);
    fx3Ready = 1'b0;
    step(3);
    check("idle_after_switch", 32'(burstActive), 32'h0);
    fx3Watermark = 1'b1;
    fx3Ready     = 1'b1;
    step(3);
    check("idle_holds_on_wm", 32'(burstActive), 32'h0);
    fx3Watermark = 1'b0;
    cycle(a1, w1, b1);
    cycle(a2, w2, b2);
    check("idle_to_burst", 32'({b1, b2}), 32'h1);
    step(8);
    end_burst();

    // Burst cap with a full FIFO.
    for (int i = 0; i < 10; i++) push(10'($urandom));
    drive_fifo();
    fx3Ready = 1'b1;
    acks = 0;
    seen = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle(a1, w1, b1);
      if (a1) acks++;
      if (burstActive) seen = 1;
      else if (seen) done = 1;
    end
    check("cap_burst_ended", 32'(done), 32'h1);
    check("cap_ack_count", 32'(acks), 32'(MAXB));
    check("cap_no_error", 32'(errorFlag), 32'h0);
    end_burst();

    // Random legal traffic with FIFO bubbles.
    stall_en = 1'b1;
    for (int b = 0; b < 25; b++) rand_burst($urandom_range(6));
    for (int b = 0; b < 60 && fifo_q.size() > 0; b++) rand_burst(0);
    step(4);
    check("drain_fifo_empty", 32'(fifo_q.size()), 32'h0);
    check("drain_all_written", 32'(exp_q.size()), 32'h0);
    stall_en = 1'b0;

    // Protocol violation: ready drops mid-burst without watermark.
    for (int i = 0; i < 3; i++) push(10'($urandom));
    drive_fifo();
    fx3Ready = 1'b1;
    step(1);
    fx3Ready = 1'b0;
    step(3);
    check("violation_error", 32'(errorFlag), 32'h1);
    fx3Watermark = 1'b0;
    step(2);
    fx3Ready = 1'b1;
    step(6);
    end_burst();
    check("error_sticky", 32'(errorFlag), 32'h1);

    // Reset mid-burst aborts and clears everything.
    for (int i = 0; i < 5; i++) push(10'($urandom));
    drive_fifo();
    fx3Ready = 1'b1;
    step(2);
    reset = 1'b1;
    #1;
    check("mid_rst_fifoAck", 32'(fifoAck), 32'h0);
    check("mid_rst_nWrite", 32'(fx3nWrite), 32'h1);
    check("mid_rst_data", 32'(fx3Data), 32'h0);
    check("mid_rst_active", 32'(burstActive), 32'h0);
    check("mid_rst_error", 32'(errorFlag), 32'h0);
    check("mid_rst_wordCount", wordCount, 32'h0);
    fifo_q.delete();
    exp_q.delete();
    fx3Ready = 1'b0;
    drive_fifo();
    @(posedge clock);
    #2 reset = 1'b0;
    step(2);

    // Post-reset burst still works.
    push(10'd1); push(10'd511); push(10'd513);
    drive_fifo();
    fx3Ready = 1'b1;
    step(6);
    end_burst();
    check("post_rst_written", 32'(exp_q.size()), 32'h0);
    check("post_rst_error", 32'(errorFlag), 32'h0);

`ifdef FX3_WORD_COUNT_EN
    force dut.r_word_count = 32'hFFFFFFFE;
    n_writes = 32'hFFFFFFFE;
    #1 release dut.r_word_count;
    push(10'd7); push(10'd8); push(10'd9);
    drive_fifo();
    fx3Ready = 1'b1;
    step(6);
    end_burst();
    check("word_count_wrap", wordCount, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
